fifo_push_arbiter: RTL

Round-robin arbiter sharing one sync FIFO's push port between N_REQ producers. Grants one requester at a time for a burst of up to MAX_BURST beats. Drives the FIFO's push/data_in directly from the granted requester. Never pushes while the FIFO reports full. Sits between producer blocks and the FIFO instance.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 38 +++
 rtl/fifo_push_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO push arbiter
//
// Contents:
//   arb_state_t : arbiter FSM states (ARB_IDLE, ARB_BURST)
//   STAT_W      : width of each per-requester statistics counter
//   id_w()      : width of a requester index for a given requester count
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Keeps index vectors at least one bit wide even for a single requester.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Finds the first set bit of req searching upward from start, wrapping
// from N_REQ-1 back to 0.
// Ports:
//   req   in  N_REQ  request vector
//   start in  ID_W   index where the search begins (must be < N_REQ)
//   found out 1      at least one request bit set
//   idx   out ID_W   winning index (0 when nothing found)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    int              cand;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand     = (int'(start) + i) % N_REQ;
            cand_idx = ID_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin arbiter for a shared FIFO push port
//
// Grants one requester at a time for a burst of up to MAX_BURST beats and
// drives the FIFO push/data directly from the granted requester. Never
// pushes while fifo_full is high. Optional macro ARB_STATS_EN adds
// saturating per-requester beat counters on stat_cnt.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   req_valid    in   per-requester beat valid
//   req_data     in   flattened beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out  one-hot (or zero) accept strobe
//   fifo_full    in   FIFO full flag
//   fifo_push    out  FIFO push
//   fifo_data    out  FIFO data_in (0 in IDLE)
//   grant_id     out  currently granted requester index
//   grant_active out  high while in BURST
//   stat_cnt     out  per-requester accepted-beat counts (ARB_STATS_EN only)
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_push,
    output logic [DATA_WIDTH-1:0]       fifo_data,
    output logic [id_w(N_REQ)-1:0]      grant_id,
    output logic                        grant_active
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]     stat_cnt
`endif
);

    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [ID_W-1:0]       grant_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                grant_valid = req_valid[i];
                grant_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        grant_next = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        burst_cnt_d  = burst_cnt_q;
        req_ready    = '0;
        fifo_push    = 1'b0;
        fifo_data    = '0;
        grant_active = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ARB_BURST;
                end
            end
            ARB_BURST: begin
                grant_active = 1'b1;
                fifo_data    = grant_data;
                if (grant_valid && !fifo_full) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready[i] = (grant_id_q == ID_W'(i));
                    end
                    fifo_push   = 1'b1;
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = grant_next;
                    end
                end else if (!grant_valid) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = grant_next;
                end
                // fifo_full with valid held: stall, grant and count frozen
            end
            default: state_d = ARB_IDLE;
        endcase

        // Handshake outputs are killed immediately on reset so an in-flight
        // burst never pushes on the reset cycle.
        if (!reset) begin
            req_ready    = '0;
            fifo_push    = 1'b0;
            grant_active = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_id = grant_id_q;

`ifdef ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (fifo_push && (grant_id_q == ID_W'(i)) && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule
